// File: rtl/uart_rx_pkg.sv
// Shared UART definitions: receiver state encoding, frame width and parity sense.
package uart_rx_pkg;

    localparam int unsigned DATA_BITS = 8;

    // Parity sense values for the ODD_nEVEN parameter of the transmitter and receiver.
    localparam bit PARITY_ODD  = 1'b1;
    localparam bit PARITY_EVEN = 1'b0;

    typedef enum logic [2:0] {
        StIdle,
        StData,
        StParity,
        StStop,
        StRecover
    } uart_state_e;

    // Parity bit a correct transmitter would send for this data byte.
    function automatic logic expected_parity(input logic [DATA_BITS-1:0] data,
                                             input logic                 odd_n_even);
        return odd_n_even ? ~^data : ^data;
    endfunction

endpackage

// File: rtl/uart_sync.sv
// Multi-flop synchronizer for an asynchronous level; flops reset to 1 (line idle).
module uart_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    // Shift the raw input through the synchronizer chain.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start, 8 data bits LSB first, parity, stop; one bit per clock.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter bit          ODD_nEVEN   = PARITY_ODD,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                 UART_clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_done_tick,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 rx_busy
);

    logic                 s;
    uart_state_e          state_q, state_d;
    logic [2:0]           cnt_q, cnt_d;
    logic [DATA_BITS-1:0] buf_q, buf_d;
    logic                 perr_pend_q, perr_pend_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 tick_q, tick_d;
    logic                 perr_q, perr_d;
    logic                 ferr_q, ferr_d;
    logic                 busy_q;

    uart_sync #(
        .STAGES(SYNC_STAGES)
    ) u_sync (
        .clk_i(UART_clk),
        .rst_i(rst),
        .d_i  (rx),
        .q_o  (s)
    );

    // State and datapath registers.
    always_ff @(posedge UART_clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            buf_q       <= '0;
            perr_pend_q <= 1'b0;
            rx_data_q   <= '0;
            tick_q      <= 1'b0;
            perr_q      <= 1'b0;
            ferr_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            buf_q       <= buf_d;
            perr_pend_q <= perr_pend_d;
            rx_data_q   <= rx_data_d;
            tick_q      <= tick_d;
            perr_q      <= perr_d;
            ferr_q      <= ferr_d;
            busy_q      <= (state_d != StIdle);
        end
    end

    // Next-state and frame decode.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        buf_d       = buf_q;
        perr_pend_d = perr_pend_q;
        rx_data_d   = rx_data_q;
        tick_d      = 1'b0;
        perr_d      = perr_q;
        ferr_d      = ferr_q;

        case (state_q)
            StIdle: begin
                // No glitch filter: any low cycle is taken as a start bit.
                if (!s) begin
                    cnt_d   = '0;
                    state_d = StData;
                end
            end
            StData: begin
                buf_d = {s, buf_q[DATA_BITS-1:1]};
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == 3'(DATA_BITS - 1)) begin
                    state_d = StParity;
                end
            end
            StParity: begin
                perr_pend_d = (s != expected_parity(buf_q, ODD_nEVEN));
                state_d     = StStop;
            end
            StStop: begin
                // Data is delivered even when the frame is errored.
                rx_data_d = buf_q;
                perr_d    = perr_pend_q;
                ferr_d    = !s;
                tick_d    = 1'b1;
                state_d   = s ? StIdle : StRecover;
            end
            StRecover: begin
                // Line held low (break): wait for mark before looking for a start bit.
                if (s) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign rx_data      = rx_data_q;
    assign rx_done_tick = tick_q;
    assign parity_err   = perr_q;
    assign frame_err    = ferr_q;
    assign rx_busy      = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench: two receivers (odd/2-stage, even/3-stage) share one serial line.
module tb_uart_rx;

    typedef struct {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
        int         cyc;
    } exp_t;

    localparam int unsigned S_ODD  = 2;
    localparam int unsigned S_EVEN = 3;

    logic clk;
    logic rst;
    logic rx;

    logic [7:0] o_data, e_data;
    logic       o_tick, e_tick;
    logic       o_perr, e_perr;
    logic       o_ferr, e_ferr;
    logic       o_busy, e_busy;

    exp_t q_odd[$];
    exp_t q_even[$];
    exp_t eo, ee;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    uart_rx #(
        .ODD_nEVEN  (1'b1),
        .SYNC_STAGES(S_ODD)
    ) dut_odd (
        .UART_clk    (clk),
        .rst         (rst),
        .rx          (rx),
        .rx_data     (o_data),
        .rx_done_tick(o_tick),
        .parity_err  (o_perr),
        .frame_err   (o_ferr),
        .rx_busy     (o_busy)
    );

    uart_rx #(
        .ODD_nEVEN  (1'b0),
        .SYNC_STAGES(S_EVEN)
    ) dut_even (
        .UART_clk    (clk),
        .rst         (rst),
        .rx          (rx),
        .rx_data     (e_data),
        .rx_done_tick(e_tick),
        .parity_err  (e_perr),
        .frame_err   (e_ferr),
        .rx_busy     (e_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // Drive one bit time, starting just after a rising edge.
    task automatic send_bit(input logic b);
        @(posedge clk);
        #1 rx = b;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) send_bit(1'b1);
    endtask

    // Send a frame and queue the hand-computed result for each receiver.
    task automatic send_frame(input logic [7:0] d, input logic pbit, input logic stop,
                              input logic perr_odd, input logic perr_even);
        exp_t x;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(pbit);
        send_bit(stop);
        x.data = d;
        x.ferr = !stop;
        x.perr = perr_odd;
        x.cyc  = cyc + S_ODD + 1;
        q_odd.push_back(x);
        x.perr = perr_even;
        x.cyc  = cyc + S_EVEN + 1;
        q_even.push_back(x);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_odd_data"}, int'(o_data), 0);
        check({tag, "_odd_flags"}, int'({o_tick, o_perr, o_ferr, o_busy}), 0);
        check({tag, "_even_data"}, int'(e_data), 0);
        check({tag, "_even_flags"}, int'({e_tick, e_perr, e_ferr, e_busy}), 0);
    endtask

    // Monitor for the odd-parity receiver.
    always @(negedge clk) begin
        if (o_tick) begin
            if (q_odd.size() == 0) begin
                total++;
                bad++;
                $display("FAIL odd_unexpected_tick: got tick data=%0h expected none", o_data);
            end else begin
                eo = q_odd.pop_front();
                check("odd_data", int'(o_data), int'(eo.data));
                check("odd_perr", int'(o_perr), int'(eo.perr));
                check("odd_ferr", int'(o_ferr), int'(eo.ferr));
                check("odd_tick_cycle", cyc, eo.cyc);
            end
        end
    end

    // Monitor for the even-parity receiver.
    always @(negedge clk) begin
        if (e_tick) begin
            if (q_even.size() == 0) begin
                total++;
                bad++;
                $display("FAIL even_unexpected_tick: got tick data=%0h expected none", e_data);
            end else begin
                ee = q_even.pop_front();
                check("even_data", int'(e_data), int'(ee.data));
                check("even_perr", int'(e_perr), int'(ee.perr));
                check("even_ferr", int'(e_ferr), int'(ee.ferr));
                check("even_tick_cycle", cyc, ee.cyc);
            end
        end
    end

    initial begin
        rx  = 1'b1;
        rst = 1'b1;
        #23;
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;
        idle(4);

        // 0xA5: odd parity bit 1 is correct for odd, wrong for even.
        send_frame(8'hA5, 1'b1, 1'b1, 1'b0, 1'b1);
        idle(3);

        // 0x3C with the odd parity bit inverted (0).
        send_frame(8'h3C, 1'b0, 1'b1, 1'b1, 1'b0);
        idle(3);

        // 0xFF with stop low, line held low afterwards.
        send_frame(8'hFF, 1'b1, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) send_bit(1'b0);
        check("recover_busy_odd", int'(o_busy), 1);
        check("recover_busy_even", int'(e_busy), 1);
        idle(6);
        check("recover_idle_odd", int'(o_busy), 0);
        check("recover_idle_even", int'(e_busy), 0);
        check("ferr_hold_odd", int'(o_ferr), 1);
        check("ferr_hold_even", int'(e_ferr), 1);

        // Back-to-back frames with no idle cycle.
        send_frame(8'h01, 1'b0, 1'b1, 1'b0, 1'b1);
        send_frame(8'h80, 1'b0, 1'b1, 1'b0, 1'b1);
        idle(6);
        check("hold_data_odd", int'(o_data), 8'h80);
        check("hold_data_even", int'(e_data), 8'h80);

        // Reset asserted during data bit 4 of 0x55.
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        #2 rst = 1'b1;
        #1 check_all_zero("async_reset");
        repeat (3) @(posedge clk);
        #1 check_all_zero("held_reset");
        rx = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        idle(5);
        check("post_reset_busy_odd", int'(o_busy), 0);
        check("post_reset_busy_even", int'(e_busy), 0);

        send_frame(8'h0F, 1'b1, 1'b1, 1'b0, 1'b1);
        idle(3);

        // 0x07: parity bit 1 is correct even parity, bit 0 is not.
        send_frame(8'h07, 1'b1, 1'b1, 1'b1, 1'b0);
        idle(2);
        send_frame(8'h07, 1'b0, 1'b1, 1'b0, 1'b1);
        idle(10);

        check("odd_pending_ticks", q_odd.size(), 0);
        check("even_pending_ticks", q_even.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter ODD_nEVEN, default 1, meaning the parity sense (1 = odd parity, 0 = even parity).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, meaning the number of input synchronizer flops on rx (legal range 2..3).
REQ-003 SHALL have port UART_clk, input, 1 bit: the single clock; one serial bit time equals one UART_clk cycle.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port rx, input, 1 bit: the serial line, idle high (MARK), asynchronous to UART_clk.
REQ-006 SHALL have port rx_data, output, 8 bits: the last received data byte.
REQ-007 SHALL have port rx_done_tick, output, 1 bit: a one-cycle pulse on frame completion.
REQ-008 SHALL have port parity_err, output, 1 bit: parity mismatch in the last completed frame.
REQ-009 SHALL have port frame_err, output, 1 bit: stop bit sampled low in the last completed frame.
REQ-010 SHALL have port rx_busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-011 SHALL decode the frame format start(0), d[0]..d[7] LSB first, parity, stop(1), one bit per UART_clk cycle.
REQ-012 SHALL sample rx only through the SYNC_STAGES synchronizer; "s" below denotes the synchronized value.
REQ-013 SHALL implement states IDLE, DATA, PARITY, STOP and RECOVER.
REQ-014 IDLE: when s==0, SHALL treat that cycle as the start bit, clear the 3-bit bit counter, and go to DATA on the next cycle.
REQ-015 DATA: SHALL shift s into the byte buffer LSB first, one bit per cycle; after the 8th bit (counter==7) it SHALL go to PARITY.
REQ-016 PARITY: SHALL compute expected parity as ~^buffer when ODD_nEVEN=1 or ^buffer when ODD_nEVEN=0, latch (s != expected) as the pending parity error, and go to STOP.
REQ-017 STOP: SHALL on the next edge load rx_data=buffer, parity_err=pending parity error, frame_err=(s==0), and assert rx_done_tick for exactly one cycle.
REQ-018 STOP: SHALL go to IDLE if s==1 and to RECOVER if s==0.
REQ-019 RECOVER: SHALL stay until s==1 and then go to IDLE; no start bit is detected while in RECOVER (break/line-low handling).
REQ-020 SHALL accept a start bit in the first IDLE cycle after STOP, so back-to-back frames with zero idle cycles are received.
REQ-021 Latency: rx_done_tick SHALL rise exactly SYNC_STAGES+1 cycles after the stop bit is present on rx.
REQ-022 rx_data, parity_err and frame_err SHALL hold their values until the next rx_done_tick; data SHALL be delivered even when errored.
REQ-023 rx_busy SHALL be a registered decode of state != IDLE.
REQ-024 No start-bit glitch filtering SHALL be applied: a single-cycle low on s starts a frame.

Reset
REQ-025 rst asserted SHALL force state=IDLE, counter=0, buffer=0, synchronizer flops=1, rx_data=0, rx_done_tick=0, parity_err=0, frame_err=0 and rx_busy=0, immediately and without a clock.
REQ-026 rst asserted mid-frame SHALL discard the partial frame; after release, no rx_done_tick SHALL occur until a new complete frame is received.

Structure
REQ-027 A shared package SHALL hold the state encoding, DATA_BITS=8, and the ODD/EVEN parity constants used by both UART transmitter and receiver.
REQ-028 The synchronizer SHALL be a separate sub-module uart_sync (parameterized depth, reset value 1).

Verification
REQ-029 Transmit 0xA5 with odd parity (parity bit 1) and stop=1 -> rx_data=0xA5, parity_err=0, frame_err=0, one tick at stop+SYNC_STAGES+1.
REQ-030 Transmit 0x3C with the parity bit inverted -> rx_data=0x3C, parity_err=1, frame_err=0.
REQ-031 Transmit 0xFF with stop=0 and the line held low for 5 cycles -> frame_err=1, state RECOVER, no new frame starts until rx returns high.
REQ-032 Send two frames back-to-back, 0x01 then 0x80, with no idle cycle between them -> two ticks 11 cycles apart, rx_data 0x01 then 0x80.
REQ-033 Assert rst at data bit 4 of frame 0x55, then send 0x0F -> all outputs 0 during reset, a single tick follows with rx_data=0x0F.
REQ-034 Set ODD_nEVEN=0 and send 0x07 with parity bit 1 -> parity_err=0; the same frame with parity bit 0 -> parity_err=1.
